spiral_gen_param: RTL and testbench

SPIRAL_GEN_PARAM -- requirements
Module: spiral_gen_param

---
 rtl/spiral_pkg.sv | 37 +++
 rtl/spiral_polar.sv | 68 ++++++
 rtl/spiral_gen_param.sv | 175 +++++++++++++++++
 tb/tb_spiral_gen_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spiral_pkg.sv
// Shared definitions for the spiral pattern generator.
//   PALETTE      : 8-entry colour table, 6-bit {R1,G1,B1,R0,G0,B0}
//   ST_*         : ping-pong FSM state encoding
//   MODE_*       : rotation mode encoding seen on the mode port
//   abs11        : magnitude of an 11-bit signed coordinate offset
package spiral_pkg;

    localparam logic [1:0] ST_FWD     = 2'd0;
    localparam logic [1:0] ST_PAUSE_F = 2'd1;
    localparam logic [1:0] ST_REV     = 2'd2;
    localparam logic [1:0] ST_PAUSE_R = 2'd3;

    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_REV = 2'b01;
    localparam logic [1:0] MODE_PP  = 2'b10;
    localparam logic [1:0] MODE_FRZ = 2'b11;

    // Frame counter width; comfortably covers any practical run/pause length.
    localparam int CNT_W = 16;

    // Listed from entry 7 down to entry 0 so that PALETTE[i] is entry i.
    localparam logic [7:0][5:0] PALETTE = {
        6'b010101,  // 7
        6'b111111,  // 6
        6'b101101,  // 5
        6'b001001,  // 4
        6'b011011,  // 3
        6'b010010,  // 2
        6'b110110,  // 1
        6'b100100   // 0
    };

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/spiral_polar.sv
// Stage 1 of the spiral pixel pipe: coarse polar decomposition of a pixel
// relative to the spiral centre.
//   clk, rst   : clock, asynchronous active-high reset
//   x_i, y_i   : pixel column / row
//   active_i   : visible-area flag, travels with the pixel as vld_o
//   rot_i      : rotation sampled together with the pixel
//   radius_o   : |sx| + |sy| (L1 radius)
//   octant_o   : {sx >= 0, sy >= 0, |sx| > |sy|}
//   fine_o     : half-octant bit, 2*min > max
//   vld_o      : registered active flag
//   rot_o      : registered rotation
module spiral_polar
    import spiral_pkg::*;
#(
    parameter int CENTER_X = 320,
    parameter int CENTER_Y = 240
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic        active_i,
    input  logic [7:0]  rot_i,
    output logic [11:0] radius_o,
    output logic [2:0]  octant_o,
    output logic        fine_o,
    output logic        vld_o,
    output logic [7:0]  rot_o
);

    logic signed [10:0] sx, sy;
    logic [10:0]        ax, ay, amax, amin;
    logic [11:0]        radius_d;
    logic [2:0]         octant_d;
    logic               fine_d;

    assign sx = $signed({1'b0, x_i}) - $signed(11'(CENTER_X));
    assign sy = $signed({1'b0, y_i}) - $signed(11'(CENTER_Y));
    assign ax = abs11(sx);
    assign ay = abs11(sy);

    assign amax = (ax > ay) ? ax : ay;
    assign amin = (ax > ay) ? ay : ax;

    assign radius_d = {1'b0, ax} + {1'b0, ay};
    assign octant_d = {~sx[10], ~sy[10], ax > ay};
    // Splits each octant in two: the bit is set once the minor axis exceeds
    // half of the major axis.
    assign fine_d   = {amin, 1'b0} > {1'b0, amax};

    // ---- stage 1 register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            radius_o <= '0;
            octant_o <= '0;
            fine_o   <= 1'b0;
            vld_o    <= 1'b0;
            rot_o    <= '0;
        end else begin
            radius_o <= radius_d;
            octant_o <= octant_d;
            fine_o   <= fine_d;
            vld_o    <= active_i;
            rot_o    <= rot_i;
        end
    end

endmodule

// File: rtl/spiral_gen_param.sv
// Rotating multi-arm spiral pattern generator.
//   clk, rst        : clock, asynchronous active-high reset
//   pattern_enable  : enables animation and colour output
//   x, y            : pixel column / row
//   active          : visible-area flag
//   next_frame      : one-cycle frame strobe
//   step_size       : rotation step per frame, quarter-LSB units of rotation
//   mode            : 00 forward, 01 reverse, 10 ping-pong, 11 frozen
//   rgb             : registered colour {R1,G1,B1,R0,G0,B0}, 2-cycle latency
module spiral_gen_param
    import spiral_pkg::*;
#(
    parameter int NUM_ARMS     = 6,
    parameter int CENTER_X     = 320,
    parameter int CENTER_Y     = 240,
    parameter int RADIUS_SHIFT = 2,
    parameter int MIN_RADIUS   = 20,
    parameter int RUN_FRAMES   = 120,
    parameter int PAUSE_FRAMES = 30
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       pattern_enable,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       next_frame,
    input  logic [2:0] step_size,
    input  logic [1:0] mode,
    output logic [5:0] rgb
);

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);

    logic [9:0]       acc_q, acc_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       step10;

    assign step10 = {7'b0, step_size};

    // Animation control: everything moves only on an enabled frame strobe,
    // so a mode change written mid-frame waits for the next strobe.
    always_comb begin
        acc_d   = acc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pattern_enable && next_frame) begin
            case (mode)
                MODE_FWD: begin
                    acc_d   = acc_q + step10;
                    state_d = ST_FWD;
                    cnt_d   = '0;
                end
                MODE_REV: begin
                    acc_d   = acc_q - step10;
                    state_d = ST_FWD;
                    cnt_d   = '0;
                end
                MODE_FRZ: begin
                    state_d = ST_FWD;
                    cnt_d   = '0;
                end
                default: begin
                    // Ping-pong: the current state decides this frame's
                    // motion; the last frame of a phase also moves on.
                    case (state_q)
                        ST_FWD: begin
                            acc_d = acc_q + step10;
                            if (cnt_q == RUN_LAST) begin
                                state_d = ST_PAUSE_F;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        ST_PAUSE_F: begin
                            if (cnt_q == PAUSE_LAST) begin
                                state_d = ST_REV;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        ST_REV: begin
                            acc_d = acc_q - step10;
                            if (cnt_q == RUN_LAST) begin
                                state_d = ST_PAUSE_R;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt_q == PAUSE_LAST) begin
                                state_d = ST_FWD;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            state_q <= ST_FWD;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [11:0] radius_p1;
    logic [2:0]  octant_p1;
    logic        fine_p1;
    logic        vld_p1;
    logic [7:0]  rot_p1;

    // Rotation is captured alongside the pixel, so the pixel presented in
    // the strobe cycle still sees the old rotation.
    spiral_polar #(
        .CENTER_X (CENTER_X),
        .CENTER_Y (CENTER_Y)
    ) u_polar (
        .clk      (clk),
        .rst      (rst),
        .x_i      (x),
        .y_i      (y),
        .active_i (active),
        .rot_i    (acc_q[9:2]),
        .radius_o (radius_p1),
        .octant_o (octant_p1),
        .fine_o   (fine_p1),
        .vld_o    (vld_p1),
        .rot_o    (rot_p1)
    );

    logic [7:0]  base_p1, angle_p1, rad_sh_p1, phase_p1;
    logic [11:0] prod_p1;
    logic [3:0]  arm_p1;
    logic        in_arm_p1;
    logic [5:0]  rgb_d, rgb_q;

    assign base_p1   = {octant_p1, fine_p1, 4'b0};
    assign angle_p1  = base_p1 + rot_p1;
    assign rad_sh_p1 = 8'(radius_p1 >> RADIUS_SHIFT);
    assign phase_p1  = angle_p1 - rad_sh_p1;
    // Scaling the phase by the arm count makes the top nibble the arm index
    // and bit 7 the half-period that separates an arm from its gap.
    assign prod_p1   = {4'b0, phase_p1} * 12'(NUM_ARMS);
    assign arm_p1    = 4'(prod_p1 >> 8);
    assign in_arm_p1 = ~prod_p1[7] && (radius_p1 > 12'(MIN_RADIUS));

    assign rgb_d = (vld_p1 && in_arm_p1 && pattern_enable) ? PALETTE[3'(arm_p1)] : 6'b0;

    // ---- stage 2 register boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_spiral_gen_param.sv
module tb_spiral_gen_param;

    localparam logic [5:0] PAL0 = 6'b100100;
    localparam logic [5:0] PAL2 = 6'b010010;
    localparam logic [5:0] PAL3 = 6'b011011;
    localparam logic [5:0] PAL4 = 6'b001001;
    localparam logic [5:0] PAL5 = 6'b101101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pattern_enable = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       active = 1'b0;
    logic       next_frame = 1'b0;
    logic [2:0] step_size = '0;
    logic [1:0] mode = '0;
    logic [5:0] rgb;

    spiral_gen_param #(
        .NUM_ARMS     (6),
        .CENTER_X     (320),
        .CENTER_Y     (240),
        .RADIUS_SHIFT (2),
        .MIN_RADIUS   (20),
        .RUN_FRAMES   (4),
        .PAUSE_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pattern_enable (pattern_enable),
        .x              (x),
        .y              (y),
        .active         (active),
        .next_frame     (next_frame),
        .step_size      (step_size),
        .mode           (mode),
        .rgb            (rgb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each expected colour is due on a known cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: output slot missed, expected %0d", e.name, e.exp);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check(e.name, int'(rgb), int'(e.exp));
        end
    end

    // Drive one pixel for one cycle; its colour is due two edges later.
    task automatic pix(input int px, input int py, input bit pa, input bit strobe,
                       input logic [5:0] e, input string nm);
        @(posedge clk); #1;
        x          = 10'(px);
        y          = 10'(py);
        active     = pa;
        next_frame = strobe;
        q.push_back('{cyc + 2, e, nm});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            active     = 1'b0;
            next_frame = 1'b0;
        end
    endtask

    task automatic frame();
        @(posedge clk); #1;
        active     = 1'b0;
        next_frame = 1'b1;
        @(posedge clk); #1;
        next_frame = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        q.delete();
        idle(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int pp_acc[13]   = '{4, 8, 12, 16, 16, 16, 12, 8, 4, 0, 0, 0, 4};
    int pp_state[13] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        #1;
        check("reset_rgb", int'(rgb), 0);
        check("reset_acc", int'(dut.acc_q), 0);
        check("reset_state", int'(dut.state_q), 0);
        @(negedge clk);
        rst = 1'b0;

        // Pixel path at rotation 0
        pattern_enable = 1'b1;
        mode = 2'b00;
        step_size = 3'd0;
        pix(320, 240, 1, 0, 6'b0, "center");
        pix(420, 240, 1, 0, 6'b0, "r100_gap");
        pix(360, 240, 1, 0, PAL5, "east40");
        pix(280, 240, 1, 0, PAL2, "west40");
        pix(320, 280, 1, 0, PAL4, "south40");
        pix(340, 240, 1, 0, 6'b0, "r20_core");
        pix(341, 240, 1, 0, PAL5, "r21_edge");
        pix(340, 250, 1, 0, PAL5, "ese");
        pix(305, 225, 1, 0, PAL0, "nw");
        pix(335, 225, 1, 0, PAL3, "ne");
        pix(290, 200, 1, 0, 6'b0, "nnw_gap");
        pix(360, 240, 0, 0, 6'b0, "inactive");
        idle(3);

        // Rotation takes effect from the pixel after the strobe
        step_size = 3'd4;
        pix(290, 200, 1, 1, 6'b0, "strobe_pixel_old_rot");
        pix(290, 200, 1, 0, PAL0, "next_pixel_new_rot");
        idle(3);
        check("fwd_acc_1", int'(dut.acc_q), 4);

        // Forward: 8 frames of step 4
        for (int i = 0; i < 7; i++) frame();
        check("fwd_acc_8", int'(dut.acc_q), 32);
        check("fwd_rotation", int'(dut.acc_q) >> 2, 8);
        pix(290, 200, 1, 0, PAL0, "rot8_nnw");
        pix(360, 240, 1, 0, PAL5, "rot8_east");
        idle(3);

        // Asynchronous reset mid-line
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            x = 10'd360; y = 10'd240; active = 1'b1;
        end
        @(posedge clk); #3;
        check("pre_reset_rgb", int'(rgb), int'(PAL5));
        rst = 1'b1;
        #1;
        check("async_reset_rgb", int'(rgb), 0);
        check("async_reset_acc", int'(dut.acc_q), 0);
        check("async_reset_state", int'(dut.state_q), 0);
        @(negedge clk);
        check("in_reset_rgb", int'(rgb), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("refill_rgb", int'(rgb), 0);
        pix(360, 240, 1, 0, PAL5, "after_reset_east");
        idle(3);

        // Reverse: 4 frames of step 1 from 0
        mode = 2'b01;
        step_size = 3'd1;
        for (int i = 0; i < 4; i++) frame();
        check("rev_acc", int'(dut.acc_q), 1020);
        check("rev_rotation", int'(dut.acc_q) >> 2, 255);
        pix(360, 240, 1, 0, 6'b0, "rot255_east");
        pix(305, 225, 1, 0, PAL0, "rot255_nw");
        idle(3);

        // Frozen and disabled both hold
        mode = 2'b11;
        frame();
        check("frozen_acc", int'(dut.acc_q), 1020);
        mode = 2'b00;
        pattern_enable = 1'b0;
        frame();
        check("disabled_acc", int'(dut.acc_q), 1020);
        pix(305, 225, 1, 0, 6'b0, "disabled_rgb");
        idle(3);
        pattern_enable = 1'b1;

        // Ping-pong from a clean reset
        do_reset();
        mode = 2'b10;
        step_size = 3'd4;
        for (int i = 0; i < 13; i++) begin
            frame();
            check($sformatf("pp_acc_f%0d", i + 1), int'(dut.acc_q), pp_acc[i]);
            check($sformatf("pp_state_f%0d", i + 1), int'(dut.state_q), pp_state[i]);
        end

        // Mode change waits for the next strobe, then forces FWD
        for (int i = 0; i < 3; i++) frame();
        check("pp_reach_pause", int'(dut.state_q), 1);
        mode = 2'b00;
        idle(4);
        check("mode_change_pending_state", int'(dut.state_q), 1);
        check("mode_change_pending_acc", int'(dut.acc_q), 16);
        frame();
        check("mode_change_state", int'(dut.state_q), 0);
        check("mode_change_acc", int'(dut.acc_q), 20);
        mode = 2'b10;
        frame();
        check("pp_resume_acc", int'(dut.acc_q), 24);
        check("pp_resume_state", int'(dut.state_q), 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
